switch_debouncer: RTL and testbench

Conditions the raw board switch before it reaches the S-Machine top level. The block synchronises the asynchronous pad, filters contact bounce with a counter-based state machine, and drives a clean level into the top level's `switch` input. It also produces single-cycle rise/fall event pulses and a saturating press counter for board diagnostics.

---
 rtl/s_machine_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/switch_debouncer.sv | 159 +++++++++++++++
 tb/tb_switch_debouncer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/s_machine_pkg.sv
// Shared definitions for the S-Machine board and top level: the switch
// filter state encoding and the default debounce length.
package s_machine_pkg;

    // Debounce filter states, 2-bit encoding shared with top-level code
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_e;

    // Default number of stable synchronised cycles before a new level is accepted
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Press counter width and its saturation value
    localparam int        PRESS_W   = 8;
    localparam logic [7:0] PRESS_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous pad inputs.
// Both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1_r;
    logic sync2_r;

    // Two-stage metastability filter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
        end
    end

    assign q = sync2_r;

endmodule

// File: rtl/switch_debouncer.sv
// Board switch conditioner: synchronises the pad, filters contact bounce
// with a counter-based FSM and produces a clean level, one-cycle edge
// pulses and a saturating press counter. All outputs are registered.
module switch_debouncer
    import s_machine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         switch_raw,
    input  logic         count_clear,
    output logic         switch,
    output logic         rise_pulse,
    output logic         fall_pulse,
    output logic [7:0]   press_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_s;
    deb_state_e       state_r;
    deb_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             rise_evt_s;
    logic             fall_evt_s;

    logic             switch_r;
    logic             rise_r;
    logic             fall_r;
    logic [7:0]       press_r;
    logic             switch_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;
    logic [7:0]       press_nxt_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (switch_raw),
        .q     (sync_s)
    );

    // State and debounce counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= STABLE_LO;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: any disagreeing sample aborts a pending transition;
    // a disabled block holds everything
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rise_evt_s  = 1'b0;
        fall_evt_s  = 1'b0;
        if (enable) begin
            case (state_r)
                STABLE_LO: begin
                    if (sync_s) begin
                        state_nxt_s = PEND_HI;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = STABLE_LO;
                    end
                end
                PEND_HI: begin
                    if (!sync_s) begin
                        state_nxt_s = STABLE_LO;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = STABLE_HI;
                        rise_evt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync_s) begin
                        state_nxt_s = PEND_LO;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = STABLE_HI;
                    end
                end
                PEND_LO: begin
                    if (sync_s) begin
                        state_nxt_s = STABLE_HI;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = STABLE_LO;
                        fall_evt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Output next values: level follows accepted edges, clear beats a rise
    always_comb begin
        switch_nxt_s = switch_r;
        rise_nxt_s   = rise_evt_s;
        fall_nxt_s   = fall_evt_s;
        press_nxt_s  = press_r;
        if (rise_evt_s) begin
            switch_nxt_s = 1'b1;
        end else if (fall_evt_s) begin
            switch_nxt_s = 1'b0;
        end else begin
            switch_nxt_s = switch_r;
        end
        if (count_clear) begin
            press_nxt_s = 8'd0;
        end else if (rise_evt_s && (press_r != PRESS_MAX)) begin
            press_nxt_s = press_r + 8'd1;
        end else begin
            press_nxt_s = press_r;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            switch_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            press_r  <= 8'd0;
        end else begin
            switch_r <= switch_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
            press_r  <= press_nxt_s;
        end
    end

    assign switch      = switch_r;
    assign rise_pulse  = rise_r;
    assign fall_pulse  = fall_r;
    assign press_count = press_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=4),
// with a second instance at DEBOUNCE_CYCLES=1 sharing the same inputs.
module tb_switch_debouncer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       switch_raw;
    logic       count_clear;
    logic       sw4, rise4, fall4;
    logic [7:0] press4;
    logic       sw1, rise1, fall1;
    logic [7:0] press1;

    int tests_run    = 0;
    int tests_failed = 0;
    int rise_seen;

    switch_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .switch_raw  (switch_raw),
        .count_clear (count_clear),
        .switch      (sw4),
        .rise_pulse  (rise4),
        .fall_pulse  (fall4),
        .press_count (press4)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .switch_raw  (switch_raw),
        .count_clear (count_clear),
        .switch      (sw1),
        .rise_pulse  (rise1),
        .fall_pulse  (fall1),
        .press_count (press1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // advance one active edge; outputs then reflect that edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // full press or release with DEBOUNCE_CYCLES=4: transition lands on edge 6
    task automatic drive_level(input logic lvl);
        switch_raw = lvl;
        repeat (7) step();
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        switch_raw  = 1'b0;
        count_clear = 1'b0;

        // ---------------- clean press ----------------
        do_reset(2);
        check_eq("rst_switch", 32'(sw4), 32'd0);
        check_eq("rst_rise", 32'(rise4), 32'd0);
        check_eq("rst_fall", 32'(fall4), 32'd0);
        check_eq("rst_press", 32'(press4), 32'd0);
        switch_raw = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            check_eq("clean_sw_low", 32'(sw4), 32'd0);
            check_eq("clean_rise_low", 32'(rise4), 32'd0);
            if (e == 2) check_eq("min_sw_e2", 32'(sw1), 32'd0);
            if (e == 3) begin
                check_eq("min_sw_e3", 32'(sw1), 32'd1);
                check_eq("min_rise_e3", 32'(rise1), 32'd1);
                check_eq("min_fall_e3", 32'(fall1), 32'd0);
                check_eq("min_press_e3", 32'(press1), 32'd1);
            end
        end
        step();
        check_eq("clean_sw_e6", 32'(sw4), 32'd1);
        check_eq("clean_rise_e6", 32'(rise4), 32'd1);
        check_eq("clean_press_e6", 32'(press4), 32'd1);
        step();
        check_eq("clean_rise_e7", 32'(rise4), 32'd0);
        check_eq("clean_sw_e7", 32'(sw4), 32'd1);

        // ---------------- bounce ----------------
        switch_raw = 1'b0;
        do_reset(2);
        rise_seen = 0;
        for (int b = 0; b < 4; b++) begin
            switch_raw = b[0] ? 1'b0 : 1'b1;
            step();
            check_eq("bounce_sw", 32'(sw4), 32'd0);
            if (rise4) rise_seen++;
        end
        switch_raw = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            check_eq("bounce_hold_sw", 32'(sw4), 32'd0);
            if (rise4) rise_seen++;
        end
        step();
        check_eq("bounce_sw_e6", 32'(sw4), 32'd1);
        if (rise4) rise_seen++;
        step();
        if (rise4) rise_seen++;
        check_eq("bounce_rise_count", 32'(rise_seen), 32'd1);
        check_eq("bounce_press", 32'(press4), 32'd1);

        // ---------------- release ----------------
        switch_raw = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            step();
            check_eq("rel_sw_high", 32'(sw4), 32'd1);
        end
        step();
        check_eq("rel_sw_e6", 32'(sw4), 32'd0);
        check_eq("rel_fall_e6", 32'(fall4), 32'd1);
        check_eq("rel_rise_e6", 32'(rise4), 32'd0);
        check_eq("rel_press", 32'(press4), 32'd1);
        step();
        check_eq("rel_fall_e7", 32'(fall4), 32'd0);

        // ---------------- enable freeze inside PEND_LO ----------------
        drive_level(1'b1);
        check_eq("frz_press_up", 32'(press4), 32'd2);
        step();
        switch_raw = 1'b0;
        repeat (4) step();          // edges 0..3: PEND_LO entered at edge 2
        enable = 1'b0;
        repeat (3) begin
            step();
            check_eq("frz_sw_hold", 32'(sw4), 32'd1);
        end
        enable = 1'b1;
        step();                     // edge 7
        step();                     // edge 8
        check_eq("frz_sw_e8", 32'(sw4), 32'd1);
        check_eq("frz_fall_e8", 32'(fall4), 32'd0);
        step();                     // edge 9
        check_eq("frz_sw_e9", 32'(sw4), 32'd0);
        check_eq("frz_fall_e9", 32'(fall4), 32'd1);
        check_eq("frz_press", 32'(press4), 32'd2);

        // ---------------- saturation and clear ----------------
        do_reset(1);
        for (int p = 0; p < 256; p++) begin
            drive_level(1'b1);
            drive_level(1'b0);
        end
        check_eq("sat_press_255", 32'(press4), 32'd255);
        switch_raw = 1'b1;
        repeat (6) step();
        count_clear = 1'b1;
        step();                     // edge 6: 257th rise together with clear
        count_clear = 1'b0;
        check_eq("clr_rise", 32'(rise4), 32'd1);
        check_eq("clr_press", 32'(press4), 32'd0);
        drive_level(1'b0);
        drive_level(1'b1);
        check_eq("clr_next_press", 32'(press4), 32'd1);
        drive_level(1'b0);

        // ---------------- reset mid-pend ----------------
        switch_raw = 1'b1;
        repeat (4) step();          // PEND_HI since edge 2
        rst_n = 1'b0;
        step();
        check_eq("midrst_sw", 32'(sw4), 32'd0);
        check_eq("midrst_rise", 32'(rise4), 32'd0);
        check_eq("midrst_fall", 32'(fall4), 32'd0);
        check_eq("midrst_press", 32'(press4), 32'd0);
        rst_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            check_eq("midrst_sw_low", 32'(sw4), 32'd0);
        end
        step();
        check_eq("midrst_sw_e6", 32'(sw4), 32'd1);
        check_eq("midrst_rise_e6", 32'(rise4), 32'd1);
        check_eq("midrst_press_e6", 32'(press4), 32'd1);

        // ---------------- clear honoured while disabled ----------------
        step();
        enable      = 1'b0;
        count_clear = 1'b1;
        step();
        check_eq("dis_clear_press", 32'(press4), 32'd0);
        check_eq("dis_clear_sw", 32'(sw4), 32'd1);
        enable      = 1'b1;
        count_clear = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
